// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port data memory between the processor
//               load/store path and the pipelined image pixel reader.
//               Bounded round-robin arbitration (MAX_RUN consecutive grants
//               to one side while the other waits), drives the memory port,
//               steers 1-cycle-latency read data back to the requester that
//               issued the read, and stalls the processor until its access
//               completes.
// Ports       : clk, rst                    clock / synchronous active-high reset
//               cpu_req/we/addr/wdata       processor request (held until done)
//               cpu_gnt/rvalid/rdata/stall  processor response and stall
//               pix_req/addr                pixel reader read request
//               pix_gnt/rvalid/rdata        pixel reader response
//               mem_en/we/addr/wdata        memory port drive
//               mem_rdata                   memory read data (1 cycle latency)
//               stall_cnt                   processor stall cycle counter
// Options     : define ARB_STALL_CNT_EN to build the saturating stall cycle
//               counter; otherwise stall_cnt is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int MAX_RUN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          pix_req,
    input  logic [AW-1:0] pix_addr,
    output logic          pix_gnt,
    output logic          pix_rvalid,
    output logic [DW-1:0] pix_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [15:0]   stall_cnt
);

    typedef enum logic {
        OWNER_CPU = 1'b0,
        OWNER_PIX = 1'b1
    } owner_e;

    localparam int               c_RUN_W   = $clog2(MAX_RUN + 1);
    localparam logic [c_RUN_W-1:0] c_MAX_RUN = c_RUN_W'(MAX_RUN);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    owner_e               r_last_owner_q, w_last_owner_d;
    logic [c_RUN_W-1:0]   r_run_cnt_q,    w_run_cnt_d;
    logic                 r_cpu_wait_q,   w_cpu_wait_d;
    logic                 r_rd_vld_q,     w_rd_vld_d;
    owner_e               r_rd_owner_q,   w_rd_owner_d;
    logic [DW-1:0]        r_cpu_rdata_q,  w_cpu_rdata_d;
    logic [DW-1:0]        r_pix_rdata_q,  w_pix_rdata_d;

    logic w_cpu_elig;
    logic w_pix_elig;
    logic w_cpu_gnt;
    logic w_pix_gnt;
    logic w_cpu_rvalid;
    logic w_pix_rvalid;
    logic w_cpu_stall;

    // The CPU is blocked for the cycle its load data returns so the same
    // (still asserted) request is not issued a second time.
    assign w_cpu_elig = cpu_req & ~r_cpu_wait_q;
    assign w_pix_elig = pix_req;

    // ------------------------------------------------------------------
    // Grant: at most one per cycle; everything forced idle during reset
    // ------------------------------------------------------------------
    always_comb begin
        w_cpu_gnt = 1'b0;
        w_pix_gnt = 1'b0;
        if (!rst) begin
            if (w_cpu_elig && w_pix_elig) begin
                // Current owner keeps the port until its run is exhausted.
                if (r_run_cnt_q < c_MAX_RUN) begin
                    w_cpu_gnt = (r_last_owner_q == OWNER_CPU);
                    w_pix_gnt = (r_last_owner_q == OWNER_PIX);
                end else begin
                    w_cpu_gnt = (r_last_owner_q == OWNER_PIX);
                    w_pix_gnt = (r_last_owner_q == OWNER_CPU);
                end
            end else begin
                w_cpu_gnt = w_cpu_elig;
                w_pix_gnt = w_pix_elig;
            end
        end
    end

    // Read data returns to whichever side issued the read last cycle;
    // a reset in the return cycle drops the delivery.
    assign w_cpu_rvalid = ~rst & r_rd_vld_q & (r_rd_owner_q == OWNER_CPU);
    assign w_pix_rvalid = ~rst & r_rd_vld_q & (r_rd_owner_q == OWNER_PIX);

    assign w_cpu_stall  = ~rst & cpu_req & ~(w_cpu_gnt & cpu_we) & ~w_cpu_rvalid;

    // ------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------
    always_comb begin
        w_last_owner_d = r_last_owner_q;
        w_run_cnt_d    = r_run_cnt_q;
        if (w_cpu_gnt || w_pix_gnt) begin
            if ((w_pix_gnt ? OWNER_PIX : OWNER_CPU) == r_last_owner_q) begin
                if (r_run_cnt_q != c_MAX_RUN) begin
                    w_run_cnt_d = r_run_cnt_q + 1'b1;
                end
            end else begin
                w_last_owner_d = w_pix_gnt ? OWNER_PIX : OWNER_CPU;
                w_run_cnt_d    = c_RUN_W'(1);
            end
        end

        w_cpu_wait_d  = w_cpu_gnt & ~cpu_we;
        w_rd_vld_d    = (w_cpu_gnt & ~cpu_we) | w_pix_gnt;
        w_rd_owner_d  = w_pix_gnt ? OWNER_PIX : OWNER_CPU;

        // Non-returning side keeps presenting its last delivered word.
        w_cpu_rdata_d = w_cpu_rvalid ? mem_rdata : r_cpu_rdata_q;
        w_pix_rdata_d = w_pix_rvalid ? mem_rdata : r_pix_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_owner_q <= OWNER_CPU;
            r_run_cnt_q    <= '0;
            r_cpu_wait_q   <= 1'b0;
            r_rd_vld_q     <= 1'b0;
            r_rd_owner_q   <= OWNER_CPU;
            r_cpu_rdata_q  <= '0;
            r_pix_rdata_q  <= '0;
        end else begin
            r_last_owner_q <= w_last_owner_d;
            r_run_cnt_q    <= w_run_cnt_d;
            r_cpu_wait_q   <= w_cpu_wait_d;
            r_rd_vld_q     <= w_rd_vld_d;
            r_rd_owner_q   <= w_rd_owner_d;
            r_cpu_rdata_q  <= w_cpu_rdata_d;
            r_pix_rdata_q  <= w_pix_rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign cpu_gnt    = w_cpu_gnt;
    assign pix_gnt    = w_pix_gnt;
    assign cpu_rvalid = w_cpu_rvalid;
    assign pix_rvalid = w_pix_rvalid;
    assign cpu_stall  = w_cpu_stall;
    assign cpu_rdata  = rst ? '0 : (w_cpu_rvalid ? mem_rdata : r_cpu_rdata_q);
    assign pix_rdata  = rst ? '0 : (w_pix_rvalid ? mem_rdata : r_pix_rdata_q);

    assign mem_en     = w_cpu_gnt | w_pix_gnt;
    assign mem_we     = w_cpu_gnt & cpu_we;
    assign mem_addr   = w_cpu_gnt ? cpu_addr  : (w_pix_gnt ? pix_addr : '0);
    assign mem_wdata  = w_cpu_gnt ? cpu_wdata : '0;

`ifdef ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt_q, w_stall_cnt_d;

    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (w_cpu_stall && (r_stall_cnt_q != 16'hFFFF)) begin
            w_stall_cnt_d = r_stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
`default_nettype wire
